// File: rtl/regfile_sb_pkg.sv
// Shared types and packed-port slice helpers for the regfile_sb register file.
package regfile_sb_pkg;

   typedef enum logic {
      ST_CLEAR = 1'b0,
      ST_RUN   = 1'b1
   } state_t;

   // Low bit of port idx inside a packed bus of w-bit fields.
   function automatic int unsigned slice_lo(input int unsigned idx, input int unsigned w);
      return idx * w;
   endfunction

endpackage

// File: rtl/regfile_sb_busy.sv
// Per-entry pending-write scoreboard with one set port, one clear port and NUM_READ lookups.
module regfile_sb_busy
   import regfile_sb_pkg::*;
#(
   parameter  int unsigned DEPTH    = 32,
   parameter  int unsigned NUM_READ = 2,
   localparam int unsigned AW       = $clog2(DEPTH)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   set_en,
   input  logic [AW-1:0]          set_addr,
   input  logic                   clr_en,
   input  logic [AW-1:0]          clr_addr,
   input  logic [NUM_READ*AW-1:0] lk_addr,
   output logic [NUM_READ-1:0]    lk_busy_c
);

   logic [DEPTH-1:0] r_busy;

   // Set is applied after clear so a new producer wins a same-edge collision.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_busy <= '0;
      end else begin
         if (clr_en) r_busy[clr_addr] <= 1'b0;
         if (set_en) r_busy[set_addr] <= 1'b1;
      end
   end

   for (genvar i = 0; i < NUM_READ; i++) begin : g_lk
      assign lk_busy_c[i] = r_busy[lk_addr[slice_lo(i, AW) +: AW]];
   end

endmodule

// File: rtl/regfile_sb.sv
// Multi-read-port register file with busy scoreboard and power-up clear engine.
// Optional same-cycle write-to-read forwarding: define REGFILE_SB_BYPASS_EN.
module regfile_sb
   import regfile_sb_pkg::*;
#(
   parameter  int unsigned DATA_W   = 32,
   parameter  int unsigned DEPTH    = 32,
   parameter  int unsigned NUM_READ = 2,
   parameter  int unsigned ZERO_REG = 1,
   localparam int unsigned AW       = $clog2(DEPTH)
) (
   input  logic                       clk,
   input  logic                       reset,
   output logic                       ready,
   input  logic [NUM_READ*AW-1:0]     rd_addr,
   output logic [NUM_READ*DATA_W-1:0] rd_data,
   output logic [NUM_READ-1:0]        rd_busy,
   input  logic                       wr_en,
   input  logic [AW-1:0]              wr_addr,
   input  logic [DATA_W-1:0]          wr_data,
   input  logic                       busy_set,
   input  logic [AW-1:0]              busy_addr
);

   state_t            r_state;
   logic [AW-1:0]     r_cnt;
   logic              r_ready;
   logic [DATA_W-1:0] r_mem [DEPTH];

   logic              w_wr_ok;
   logic              w_set_ok;
   logic [NUM_READ-1:0] w_busy;

   assign w_wr_ok  = wr_en    && r_ready && !((ZERO_REG != 0) && (wr_addr   == '0));
   assign w_set_ok = busy_set && r_ready && !((ZERO_REG != 0) && (busy_addr == '0));
   assign ready    = r_ready;

   // Clear sequencer: one entry per edge, RUN on the edge that writes the last entry.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= ST_CLEAR;
         r_cnt   <= '0;
         r_ready <= 1'b0;
      end else begin
         case (r_state)
            ST_CLEAR: begin
               r_cnt <= r_cnt + AW'(1);
               if (r_cnt == AW'(DEPTH - 1)) begin
                  r_state <= ST_RUN;
                  r_ready <= 1'b1;
               end
            end
            default: begin
               r_state <= ST_RUN;
               r_ready <= 1'b1;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (r_state == ST_CLEAR) begin
         r_mem[r_cnt] <= '0;
      end else if (w_wr_ok) begin
         r_mem[wr_addr] <= wr_data;
      end
   end

   regfile_sb_busy #(
      .DEPTH    (DEPTH),
      .NUM_READ (NUM_READ)
   ) u_busy (
      .clk       (clk),
      .rst       (reset),
      .set_en    (w_set_ok),
      .set_addr  (busy_addr),
      .clr_en    (w_wr_ok),
      .clr_addr  (wr_addr),
      .lk_addr   (rd_addr),
      .lk_busy_c (w_busy)
   );

   for (genvar i = 0; i < NUM_READ; i++) begin : g_rd
      logic [AW-1:0]     w_a;
      logic              w_zero;
      logic [DATA_W-1:0] w_d;
      logic              w_b;

      assign w_a    = rd_addr[slice_lo(i, AW) +: AW];
      assign w_zero = (ZERO_REG != 0) && (w_a == '0);

      always_comb begin
         w_d = '0;
         w_b = 1'b0;
         if (r_ready && !w_zero) begin
            w_d = r_mem[w_a];
            w_b = w_busy[i];
`ifdef REGFILE_SB_BYPASS_EN
            if (wr_en && (wr_addr == w_a)) begin
               w_d = wr_data;
               w_b = 1'b0;
            end
`endif
         end
      end

      assign rd_data[slice_lo(i, DATA_W) +: DATA_W] = w_d;
      assign rd_busy[i]                             = w_b;
   end

endmodule

// File: tb/tb_regfile_sb.sv
// Randomized self-checking bench for regfile_sb against an array/scoreboard reference model.
module tb_regfile_sb;

`ifdef REGFILE_SB_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif
   localparam int N = 32;

   logic        clk = 1'b0;
   logic        reset;
   logic        ready;
   logic [9:0]  rd_addr;
   logic [63:0] rd_data;
   logic [1:0]  rd_busy;
   logic        wr_en;
   logic [4:0]  wr_addr;
   logic [31:0] wr_data;
   logic        busy_set;
   logic [4:0]  busy_addr;

   int total = 0;
   int bad   = 0;

   logic [31:0] m_mem [N];
   bit          m_busy [N];
   bit          m_ready;
   int          m_cnt;

   regfile_sb dut (
      .clk       (clk),
      .reset     (reset),
      .ready     (ready),
      .rd_addr   (rd_addr),
      .rd_data   (rd_data),
      .rd_busy   (rd_busy),
      .wr_en     (wr_en),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .busy_set  (busy_set),
      .busy_addr (busy_addr)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
      end
   endtask

   // Expected read result from the architectural rules.
   task automatic exp_rd(input logic [4:0] a, output logic [31:0] d, output logic b);
      d = 32'h0;
      b = 1'b0;
      if (m_ready && !reset && a != 5'd0) begin
         d = m_mem[a];
         b = m_busy[a];
         if (BYP && wr_en && wr_addr == a) begin
            d = wr_data;
            b = 1'b0;
         end
      end
   endtask

   // Apply inputs (at negedge), then compare all outputs with the model.
   task automatic drive(input bit rst_i, input bit we, input logic [4:0] wa, input logic [31:0] wd,
                        input bit bs, input logic [4:0] ba, input logic [4:0] a0, input logic [4:0] a1);
      logic [31:0] d;
      logic        b;
      reset = rst_i; wr_en = we; wr_addr = wa; wr_data = wd;
      busy_set = bs; busy_addr = ba; rd_addr = {a1, a0};
      if (rst_i) begin
         m_ready = 1'b0;
         m_cnt   = 0;
         for (int k = 0; k < N; k++) m_busy[k] = 1'b0;
      end
      #1;
      chk("ready", {31'b0, ready}, {31'b0, m_ready});
      exp_rd(a0, d, b);
      chk("data0", rd_data[31:0], d);
      chk("busy0", {31'b0, rd_busy[0]}, {31'b0, b});
      exp_rd(a1, d, b);
      chk("data1", rd_data[63:32], d);
      chk("busy1", {31'b0, rd_busy[1]}, {31'b0, b});
   endtask

   task automatic idle(input logic [4:0] a0, input logic [4:0] a1);
      drive(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, a0, a1);
   endtask

   // Advance one clock and update the model with the edge's effects.
   task automatic tick();
      @(posedge clk);
      if (!reset) begin
         if (!m_ready) begin
            m_mem[m_cnt] = 32'h0;
            m_cnt++;
            if (m_cnt == N) m_ready = 1'b1;
         end else begin
            if (wr_en && wr_addr != 5'd0) begin
               m_mem[wr_addr]  = wr_data;
               m_busy[wr_addr] = 1'b0;
            end
            if (busy_set && busy_addr != 5'd0) m_busy[busy_addr] = 1'b1;
         end
      end
      @(negedge clk);
   endtask

   task automatic clear_phase(input string tag);
      for (int k = 0; k < N; k++) begin
         drive(1'b0, 1'($urandom_range(0, 1)), 5'($urandom), $urandom, 1'($urandom_range(0, 1)),
               5'($urandom), 5'($urandom), 5'($urandom));
         chk({tag, "_ready_low"}, {31'b0, ready}, 32'h0);
         tick();
      end
      idle(5'd0, 5'd1);
      chk({tag, "_ready_high"}, {31'b0, ready}, 32'h1);
      for (int k = 0; k < N; k++) begin
         idle(5'(k), 5'(N - 1 - k));
         chk({tag, "_zero0"}, rd_data[31:0], 32'h0);
         chk({tag, "_zero1"}, rd_data[63:32], 32'h0);
         chk({tag, "_nobusy"}, {30'b0, rd_busy}, 32'h0);
         tick();
      end
   endtask

   initial begin
      for (int k = 0; k < N; k++) begin
         m_mem[k]  = 32'h0;
         m_busy[k] = 1'b0;
      end
      m_ready = 1'b0;
      m_cnt   = 0;

      drive(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd0);
      chk("rst_ready", {31'b0, ready}, 32'h0);
      tick();
      drive(1'b1, 1'b1, 5'd3, 32'h77, 1'b1, 5'd3, 5'd3, 5'd3);
      tick();
      clear_phase("init");

      drive(1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 5'd0, 5'd0);
      tick();
      idle(5'd5, 5'd5);
      chk("r5_p0", rd_data[31:0], 32'hDEADBEEF);
      chk("r5_p1", rd_data[63:32], 32'hDEADBEEF);
      tick();
      drive(1'b0, 1'b1, 5'd0, 32'h1234, 1'b1, 5'd0, 5'd0, 5'd0);
      chk("r0_wr_cycle", rd_data[31:0], 32'h0);
      tick();
      idle(5'd0, 5'd0);
      chk("r0_data", rd_data[31:0], 32'h0);
      chk("r0_busy", {31'b0, rd_busy[0]}, 32'h0);
      tick();

      drive(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 5'd7, 5'd7);
      chk("r7_set_cycle", {31'b0, rd_busy[0]}, 32'h0);
      tick();
      idle(5'd7, 5'd7);
      chk("r7_busy", {31'b0, rd_busy[0]}, 32'h1);
      tick();
      drive(1'b0, 1'b1, 5'd7, 32'hA5A5A5A5, 1'b0, 5'd0, 5'd7, 5'd7);
      chk("r7_wr_data", rd_data[31:0], BYP ? 32'hA5A5A5A5 : 32'h0);
      chk("r7_wr_busy", {31'b0, rd_busy[1]}, BYP ? 32'h0 : 32'h1);
      tick();
      idle(5'd7, 5'd7);
      chk("r7_after_data", rd_data[63:32], 32'hA5A5A5A5);
      chk("r7_after_busy", {31'b0, rd_busy[0]}, 32'h0);
      tick();

      drive(1'b0, 1'b1, 5'd9, 32'h55, 1'b1, 5'd9, 5'd9, 5'd9);
      chk("r9_same_busy", {31'b0, rd_busy[0]}, 32'h0);
      tick();
      idle(5'd9, 5'd9);
      chk("r9_data", rd_data[31:0], 32'h55);
      chk("r9_busy", {31'b0, rd_busy[1]}, 32'h1);
      tick();

      for (int c = 0; c < 3000; c++) begin
         logic [4:0] wa, ba, a0, a1;
         bit         narrow;
         narrow = ($urandom_range(0, 3) != 0);
         wa = narrow ? 5'($urandom_range(0, 7)) : 5'($urandom);
         ba = narrow ? 5'($urandom_range(0, 7)) : 5'($urandom);
         a0 = narrow ? 5'($urandom_range(0, 7)) : 5'($urandom);
         a1 = ($urandom_range(0, 3) == 0) ? a0 : (narrow ? 5'($urandom_range(0, 7)) : 5'($urandom));
         drive(($urandom_range(0, 499) == 0), 1'($urandom_range(0, 1)), wa, $urandom,
               1'($urandom_range(0, 2) == 0), ba, a0, a1);
         tick();
      end

      while (!m_ready) begin
         idle(5'd1, 5'd2);
         tick();
      end
      for (int k = 1; k < N; k++) begin
         drive(1'b0, 1'b1, 5'(k), 32'h01010101 * 32'(k) + 32'h1, 1'b1, 5'(N - k), 5'(k), 5'(k - 1));
         tick();
      end
      idle(5'd4, 5'd31);
      chk("fill_r4", rd_data[31:0], 32'h04040405);
      tick();
      drive(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd4, 5'd31);
      chk("midrun_ready", {31'b0, ready}, 32'h0);
      chk("midrun_data", rd_data[31:0], 32'h0);
      tick();
      clear_phase("rerun");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
